cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low (asserted at 0).
REQ-005 SHALL have port i_pmem_read  in  1  I-cache line fill request.
REQ-006 SHALL have port i_pmem_address  in  ADDR_W  I-cache line address.
REQ-007 SHALL have port i_pmem_resp  out  1  I-cache fill complete.
REQ-008 SHALL have port i_pmem_rdata  out  LINE_W  I-cache fill data.
REQ-009 SHALL have port d_pmem_read  in  1  D-cache line fill request.
REQ-010 SHALL have port d_pmem_write  in  1  D-cache line writeback request.
REQ-011 SHALL have port d_pmem_address  in  ADDR_W  D-cache line address.
REQ-012 SHALL have port d_pmem_wdata  in  LINE_W  D-cache writeback data.
REQ-013 SHALL have port d_pmem_resp  out  1  D-cache transaction complete.
REQ-014 SHALL have port d_pmem_rdata  out  LINE_W  D-cache fill data.
REQ-015 SHALL have ports mem_read, mem_write  out  1 each  line request to the cacheline adaptor.
REQ-016 SHALL have port mem_address  out  ADDR_W  line address to the adaptor.
REQ-017 SHALL have port mem_wdata  out  LINE_W  writeback data to the adaptor.
REQ-018 SHALL have port mem_resp  in  1  adaptor transaction complete.
REQ-019 SHALL have port mem_rdata  in  LINE_W  adaptor fill data.

Function
REQ-020 SHALL implement FSM states IDLE, I_BUSY, D_BUSY.
REQ-021 IDLE: only i request -> I_BUSY; only d request (read or write) -> D_BUSY; none -> stay in IDLE.
REQ-022 IDLE with both requesting: SHALL grant the client not granted last (last_grant register); last_grant updates on every grant.
REQ-023 On grant, SHALL latch the winner's address with bits [log2(LINE_W/8)-1:0] forced to 0, the op type (read/write), and for D writes d_pmem_wdata.
REQ-024 D request with read and write both high: SHALL be treated as a write.
REQ-025 Busy states: mem_read/mem_write SHALL be driven from the latched op, held high every cycle until mem_resp; mem_address/mem_wdata from latched registers, stable for the whole transaction.
REQ-026 Arbitration latency: exactly 1 cycle; the memory request is first visible in the cycle after the request is first seen in IDLE.
REQ-027 On mem_resp in I_BUSY: i_pmem_resp=1 in the same cycle (combinational), i_pmem_rdata=mem_rdata; next state IDLE.
REQ-028 On mem_resp in D_BUSY: d_pmem_resp=1 in the same cycle, d_pmem_rdata=mem_rdata; next state IDLE.
REQ-029 Exactly one resp pulse of one cycle per granted transaction; a non-granted client's resp SHALL stay 0.
REQ-030 Client dropping its request mid-transaction SHALL NOT abort the transaction; the resp still pulses.
REQ-031 mem_resp in IDLE SHALL be ignored (no client resp, no state change).
REQ-032 mem_read, mem_write SHALL be 0 in IDLE; never both 1.
REQ-033 i_pmem_rdata/d_pmem_rdata SHALL carry mem_rdata continuously; only resp is qualified.
REQ-034 Clients SHALL deassert request in the cycle after resp; a request still high in IDLE is a new request.

Reset
REQ-035 rst=0 SHALL immediately force state IDLE, mem_read=mem_write=0, i_pmem_resp=d_pmem_resp=0, latched address/wdata=0, last_grant=D (so I wins the first tie).
REQ-036 Reset mid-transaction SHALL abandon it with no resp pulse; operation resumes on the first clk edge after rst=1.

Verification
REQ-037 I read only, addr 0x0000_1234, mem_resp 4 cycles after mem_read -> mem_address=0x0000_1220, i_pmem_resp pulses 1 cycle with rdata, d_pmem_resp stays 0.
REQ-038 I and D read together from reset -> I served first, then D (D granted in the cycle after the I resp if still high); second tie -> D first.
REQ-039 D write, addr 0x8000_0040, wdata pattern A5.., client changes wdata and drops request mid-transaction -> mem_wdata/mem_address unchanged, mem_write held until mem_resp, d_pmem_resp pulses once.
REQ-040 mem_resp pulsed in IDLE with no requests -> no client resp, state stays IDLE.
REQ-041 rst=0 asserted during D_BUSY between clk edges -> mem_write drops before the next edge, no d_pmem_resp; new I request after release served normally.
REQ-042 D read and write both high -> mem_write=1, mem_read=0.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one cacheline adaptor between an I-cache (fills) and a D-cache (fills and writebacks).
// Revision 1.0
`default_nettype none

module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int OFS_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFS_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t             state_q;
  grant_t             last_grant_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LINE_W-1:0]  wdata_q;
  logic               mem_read_q;
  logic               mem_write_q;

  logic               i_req;
  logic               d_req;
  logic               grant_i;
  logic               grant_d;
  logic               write_d;
  logic [ADDR_W-1:0]  addr_d;

  // Arbitration decision; only meaningful in IDLE, ties go to whoever lost last time.
  always_comb begin
    i_req   = i_pmem_read;
    d_req   = d_pmem_read | d_pmem_write;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req && d_req) begin
        if (last_grant_q == GRANT_D) grant_i = 1'b1;
        else                         grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
    addr_d  = (grant_i ? i_pmem_address : d_pmem_address) & ~OFFSET_MASK;
    // A D request with both read and write high is a writeback.
    write_d = grant_d & d_pmem_write;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q      <= I_BUSY;
            last_grant_q <= GRANT_I;
            addr_q       <= addr_d;
            mem_read_q   <= 1'b1;
            mem_write_q  <= 1'b0;
          end else if (grant_d) begin
            state_q      <= D_BUSY;
            last_grant_q <= GRANT_D;
            addr_q       <= addr_d;
            if (write_d) wdata_q <= d_pmem_wdata;
            mem_read_q   <= ~write_d;
            mem_write_q  <= write_d;
          end
        end
        I_BUSY, D_BUSY: begin
          if (mem_resp) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;

  // Response is qualified by the owning state; data is passed through unqualified.
  assign i_pmem_resp  = (state_q == I_BUSY) & mem_resp;
  assign d_pmem_resp  = (state_q == D_BUSY) & mem_resp;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed self-checking bench for cache_arbiter.
`default_nettype none

module tb_cache_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic              i_pmem_resp;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic              d_pmem_resp;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [LINE_W-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_resp = 0; mem_rdata = '0;
    tick(); tick();
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset.mem_read got=%b want=0", mem_read); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset.mem_write got=%b want=0", mem_write); end
    total++; if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin bad++; $display("FAIL reset.resp got=%b%b want=00", i_pmem_resp, d_pmem_resp); end
    total++; if (mem_address !== 32'h0) begin bad++; $display("FAIL reset.mem_address got=%h want=0", mem_address); end
    total++; if (mem_wdata !== '0) begin bad++; $display("FAIL reset.mem_wdata got=%h want=0", mem_wdata); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_i_read();
    logic [LINE_W-1:0] pat;
    pat = {8{32'hCAFE_0001}};
    i_pmem_read = 1; i_pmem_address = 32'h0000_1234;
    #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL i_read.latency got=%b want=0", mem_read); end
    tick();
    total++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin bad++; $display("FAIL i_read.op got=r%b w%b want=r1 w0", mem_read, mem_write); end
    total++; if (mem_address !== 32'h0000_1220) begin bad++; $display("FAIL i_read.addr got=%h want=00001220", mem_address); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (mem_read !== 1'b1 || i_pmem_resp !== 1'b0) begin bad++; $display("FAIL i_read.hold got=r%b resp%b want=r1 resp0", mem_read, i_pmem_resp); end
    end
    tick();
    mem_resp = 1; mem_rdata = pat;
    #1;
    total++; if (i_pmem_resp !== 1'b1) begin bad++; $display("FAIL i_read.resp got=%b want=1", i_pmem_resp); end
    total++; if (i_pmem_rdata !== pat) begin bad++; $display("FAIL i_read.rdata got=%h want=%h", i_pmem_rdata, pat); end
    total++; if (d_pmem_resp !== 1'b0) begin bad++; $display("FAIL i_read.d_resp got=%b want=0", d_pmem_resp); end
    tick();
    mem_resp = 0; i_pmem_read = 0;
    #1;
    total++; if (i_pmem_resp !== 1'b0 || mem_read !== 1'b0) begin bad++; $display("FAIL i_read.end got=resp%b r%b want=resp0 r0", i_pmem_resp, mem_read); end
    tick();
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL i_read.idle got=%b want=0", mem_read); end
  endtask

  task automatic test_tie();
    rst = 0; tick(); rst = 1; tick();
    i_pmem_read = 1; i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1; d_pmem_address = 32'h0000_2040;
    tick();
    total++; if (mem_read !== 1'b1 || mem_address !== 32'h0000_0100) begin bad++; $display("FAIL tie1.grant got=r%b a%h want=r1 a00000100", mem_read, mem_address); end
    mem_resp = 1; #1;
    total++; if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin bad++; $display("FAIL tie1.resp got=i%b d%b want=i1 d0", i_pmem_resp, d_pmem_resp); end
    tick();
    mem_resp = 0; i_pmem_address = 32'h0000_0300;
    #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL tie1.idle got=%b want=0", mem_read); end
    tick();
    total++; if (mem_read !== 1'b1 || mem_address !== 32'h0000_2040) begin bad++; $display("FAIL tie2.grant_d got=r%b a%h want=r1 a00002040", mem_read, mem_address); end
    mem_resp = 1; #1;
    total++; if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin bad++; $display("FAIL tie2.resp got=i%b d%b want=i0 d1", i_pmem_resp, d_pmem_resp); end
    tick();
    mem_resp = 0; d_pmem_read = 0;
    tick();
    total++; if (mem_read !== 1'b1 || mem_address !== 32'h0000_0300) begin bad++; $display("FAIL tie2.then_i got=r%b a%h want=r1 a00000300", mem_read, mem_address); end
    mem_resp = 1; #1;
    total++; if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin bad++; $display("FAIL tie2.i_resp got=i%b d%b want=i1 d0", i_pmem_resp, d_pmem_resp); end
    tick();
    mem_resp = 0; i_pmem_read = 0;
    tick();
  endtask

  task automatic test_d_write();
    logic [LINE_W-1:0] wa;
    logic [LINE_W-1:0] wb;
    wa = {32{8'hA5}};
    wb = {32{8'h5A}};
    d_pmem_write = 1; d_pmem_address = 32'h8000_0040; d_pmem_wdata = wa;
    tick();
    total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL dwr.op got=r%b w%b want=r0 w1", mem_read, mem_write); end
    d_pmem_wdata = wb; d_pmem_write = 0; d_pmem_address = 32'h0000_0080;
    tick(); tick();
    total++; if (mem_write !== 1'b1 || d_pmem_resp !== 1'b0) begin bad++; $display("FAIL dwr.hold got=w%b resp%b want=w1 resp0", mem_write, d_pmem_resp); end
    total++; if (mem_wdata !== wa) begin bad++; $display("FAIL dwr.wdata got=%h want=%h", mem_wdata, wa); end
    total++; if (mem_address !== 32'h8000_0040) begin bad++; $display("FAIL dwr.addr got=%h want=80000040", mem_address); end
    mem_resp = 1; #1;
    total++; if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin bad++; $display("FAIL dwr.resp got=i%b d%b want=i0 d1", i_pmem_resp, d_pmem_resp); end
    tick();
    mem_resp = 0; #1;
    total++; if (d_pmem_resp !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL dwr.end got=resp%b w%b want=resp0 w0", d_pmem_resp, mem_write); end
    tick();
  endtask

  task automatic test_idle_resp();
    mem_resp = 1; #1;
    total++; if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin bad++; $display("FAIL idle_resp.resp got=i%b d%b want=i0 d0", i_pmem_resp, d_pmem_resp); end
    tick();
    mem_resp = 0;
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL idle_resp.mem got=r%b w%b want=r0 w0", mem_read, mem_write); end
    i_pmem_read = 1; i_pmem_address = 32'h0000_0444;
    tick();
    total++; if (mem_read !== 1'b1 || mem_address !== 32'h0000_0440) begin bad++; $display("FAIL idle_resp.still_idle got=r%b a%h want=r1 a00000440", mem_read, mem_address); end
    mem_resp = 1; tick();
    mem_resp = 0; i_pmem_read = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    d_pmem_write = 1; d_pmem_address = 32'h0000_0040; d_pmem_wdata = {8{32'h1234_5678}};
    tick();
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rstmid.pre got=%b want=1", mem_write); end
    #2;
    rst = 0; mem_resp = 1;
    #1;
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rstmid.mem_write got=%b want=0", mem_write); end
    total++; if (d_pmem_resp !== 1'b0) begin bad++; $display("FAIL rstmid.d_resp got=%b want=0", d_pmem_resp); end
    total++; if (mem_address !== 32'h0) begin bad++; $display("FAIL rstmid.addr got=%h want=0", mem_address); end
    d_pmem_write = 0; mem_resp = 0;
    tick();
    rst = 1;
    tick();
    i_pmem_read = 1; i_pmem_address = 32'h0000_0555;
    tick();
    total++; if (mem_read !== 1'b1 || mem_address !== 32'h0000_0540) begin bad++; $display("FAIL rstmid.new_i got=r%b a%h want=r1 a00000540", mem_read, mem_address); end
    mem_resp = 1; #1;
    total++; if (i_pmem_resp !== 1'b1) begin bad++; $display("FAIL rstmid.i_resp got=%b want=1", i_pmem_resp); end
    tick();
    mem_resp = 0; i_pmem_read = 0;
    tick();
  endtask

  task automatic test_rw_both();
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h0000_0C00; d_pmem_wdata = {8{32'hDEAD_BEEF}};
    tick();
    total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin bad++; $display("FAIL rw_both.op got=r%b w%b want=r0 w1", mem_read, mem_write); end
    total++; if (mem_wdata !== {8{32'hDEAD_BEEF}}) begin bad++; $display("FAIL rw_both.wdata got=%h", mem_wdata); end
    mem_resp = 1; #1;
    total++; if (d_pmem_resp !== 1'b1) begin bad++; $display("FAIL rw_both.resp got=%b want=1", d_pmem_resp); end
    tick();
    mem_resp = 0; d_pmem_read = 0; d_pmem_write = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_tie();
    test_d_write();
    test_idle_resp();
    test_reset_mid();
    test_rw_both();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
